mdiv_seq: RTL

Parametrised, handshaked successor to the single-shot mantissa divider. It computes (1.m1)/(1.m2) with a radix-2^BPC restoring recurrence. It normalises the quotient and rounds it per a selectable mode, and reports exactness and the final remainder. It sits between the FP divide front-end (exponent subtract) and the exponent-adjust/pack stage, decoupled by valid/ready on both sides.

---
 rtl/mdiv_pkg.sv | 22 ++
 rtl/mdiv_round.sv | 48 ++++
 rtl/mdiv_seq.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mdiv_pkg.sv
// Shared types and sizing helpers for the sequential mantissa divider.
package mdiv_pkg;

  typedef enum logic [1:0] {
    RNE  = 2'b00,
    RTZ  = 2'b01,
    RAZ  = 2'b10,
    RSVD = 2'b11
  } round_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mdiv_state_t;

  // Quotient bits: 1 integer, WIDTH fraction, guard, extra.
  function automatic int calc_n(input int width);
    return width + 3;
  endfunction

endpackage

// File: rtl/mdiv_round.sv
// Normalise the raw quotient, derive guard/sticky and round to WIDTH bits.
module mdiv_round
  import mdiv_pkg::*;
#(
  parameter int WIDTH = 23
) (
  input  logic [calc_n(WIDTH)-1:0] q,
  input  logic [WIDTH:0]           r,
  input  logic [1:0]               round_mode,
  output logic [WIDTH-1:0]         m3,
  output logic                     decrement_exponent,
  output logic                     exact
);
  localparam int N = calc_n(WIDTH);

  logic [WIDTH-1:0] mant;
  logic [WIDTH:0]   sum;
  logic             norm, guard, sticky, inc, carry;

  always_comb begin
    norm   = q[N-1];
    mant   = q[N-3:1];
    guard  = q[0];
    sticky = |r;
    if (norm) begin
      mant   = q[N-2:2];
      guard  = q[1];
      sticky = q[0] | (|r);
    end
    unique case (round_mode_t'(round_mode))
      RTZ:     inc = 1'b0;
      RAZ:     inc = guard | sticky;
      default: inc = guard & (sticky | mant[0]);
    endcase
    // Carry-out wraps the mantissa to zero and bumps the exponent back up.
    sum                = {1'b0, mant} + {{WIDTH{1'b0}}, inc};
    carry              = sum[WIDTH];
    m3                 = sum[WIDTH-1:0];
    decrement_exponent = ~norm & ~carry;
    exact              = ~guard & ~sticky;
  end

  // A quotient >= 1 can never round up to 2.0, so this combination is unreachable.
  always_comb begin
    assert (!(carry && norm)) else $error("mdiv_round: carry-out with normalised quotient");
  end

endmodule

// File: rtl/mdiv_seq.sv
// Handshaked radix-2^BPC restoring divider for (1.m1)/(1.m2) with registered rounding stage.
module mdiv_seq
  import mdiv_pkg::*;
#(
  parameter int WIDTH = 23,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] m1,
  input  logic [WIDTH-1:0] m2,
  input  logic [1:0]       round_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] m3,
  output logic [WIDTH:0]   r,
  output logic             decrement_exponent,
  output logic             exact
);
  localparam int N  = calc_n(WIDTH);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - BPC);
  localparam logic [CW-1:0] STEP = CW'(BPC);

  if (BPC < 1 || BPC > 2 || ((WIDTH + 3) % BPC) != 0) begin : g_bad_cfg
    $error("mdiv_seq: BPC must be 1 or 2 and divide WIDTH+3");
  end

  mdiv_state_t       state, state_nxt;
  round_mode_t       mode;
  logic [WIDTH:0]    dvs;
  logic [WIDTH+1:0]  rem, rem_nxt;
  logic [N-BPC-1:0]  quo;
  logic [BPC-1:0]    qbits;
  logic [N-1:0]      quo_nxt;
  logic [CW-1:0]     cnt;
  logic              last_cyc, accept;
  logic [WIDTH-1:0]  m3_rnd;
  logic              dec_rnd, exact_rnd;

  assign last_cyc = (state == BUSY) && (cnt == LAST);
  assign accept   = in_valid & in_ready & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) state_nxt = IDLE;
    else begin
      unique case (state)
        IDLE:    if (in_valid) state_nxt = BUSY;
        BUSY:    if (last_cyc) state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = in_valid ? BUSY : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    out_valid = (state == DONE);
  end

  // BPC restoring steps per clock; the remainder is left unshifted after the very last step.
  always_comb begin
    rem_nxt = rem;
    qbits   = '0;
    for (int s = 0; s < BPC; s++) begin
      if (rem_nxt >= {1'b0, dvs}) begin
        qbits[BPC-1-s] = 1'b1;
        rem_nxt        = rem_nxt - {1'b0, dvs};
      end
      if (!(last_cyc && s == BPC - 1)) rem_nxt = rem_nxt << 1;
    end
    quo_nxt = {quo, qbits};
  end

  mdiv_round #(.WIDTH(WIDTH)) u_round (
    .q                  (quo_nxt),
    .r                  (rem_nxt[WIDTH:0]),
    .round_mode         (mode),
    .m3                 (m3_rnd),
    .decrement_exponent (dec_rnd),
    .exact              (exact_rnd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dvs                <= '0;
      rem                <= '0;
      quo                <= '0;
      cnt                <= '0;
      mode               <= RNE;
      m3                 <= '0;
      r                  <= '0;
      decrement_exponent <= 1'b0;
      exact              <= 1'b0;
    end else if (accept) begin
      dvs  <= {1'b1, m2};
      rem  <= {2'b01, m1};
      quo  <= '0;
      cnt  <= '0;
      mode <= round_mode_t'(round_mode);
    end else if (state == BUSY && !flush) begin
      rem <= rem_nxt;
      quo <= quo_nxt[N-BPC-1:0];
      cnt <= cnt + STEP;
      if (last_cyc) begin
        m3                 <= m3_rnd;
        r                  <= rem_nxt[WIDTH:0];
        decrement_exponent <= dec_rnd;
        exact              <= exact_rnd;
      end
    end
  end

  // Final remainder must be strictly below the divisor.
  always_ff @(posedge clk) begin
    if (reset && last_cyc) begin
      assert (rem_nxt < {1'b0, dvs}) else $error("mdiv_seq: remainder not below divisor");
    end
  end

endmodule
